// File: rtl/ide_pkg.sv
// Shared IDE constants: FIFO sizing defaults and the CD sector size in 16-bit words.
package ide_pkg;
    localparam int IDE_DEPTH_LOG2   = 10;
    localparam int IDE_BURST        = 8;
    localparam int IDE_SECTOR_WORDS = 1024;
endpackage

// File: rtl/ide_fifo_ram.sv
// Simple dual-port word store: one write port, one registered read port (maps onto iCE40 EBR).
module ide_fifo_ram #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Read-before-write on a shared address keeps push+pop at full returning the old head.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/ide_word_fifo.sv
// CPU byte -> IDE word FIFO: pairs bytes little-endian into words, sticky error flags, burst request.
module ide_word_fifo
    import ide_pkg::*;
#(
    parameter int DEPTH_LOG2 = IDE_DEPTH_LOG2,
    parameter int BURST      = IDE_BURST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_wr,
    input  logic [7:0]            cpu_wdata,
    input  logic                  cpu_flush,
    input  logic                  err_clr,
    input  logic                  ide_rd,
    output logic [15:0]           ide_rdata,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  full,
    output logic                  byte_pend,
    output logic                  req,
    output logic                  overflow,
    output logic                  underflow
);
    localparam logic [DEPTH_LOG2:0] ONE     = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0] FULL_L  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] BURST_L = BURST[DEPTH_LOG2:0];

    logic [DEPTH_LOG2:0] wptr, rptr, wptr_n, rptr_n, level_n;
    logic [7:0]          lo_byte;
    logic [15:0]         ram_q;
    logic                rd_seen;
    logic                push_try, push_ok, pop_ok, ovf_ev, unf_ev;

    always_comb begin
        push_try = cpu_wr && byte_pend && !cpu_flush;
        pop_ok   = ide_rd && !empty && !cpu_flush;
        push_ok  = push_try && (!full || pop_ok);
        ovf_ev   = push_try && full && !pop_ok;
        unf_ev   = ide_rd && empty && !cpu_flush;
        wptr_n   = wptr;
        rptr_n   = rptr;
        if (cpu_flush) begin
            wptr_n = '0;
            rptr_n = '0;
        end else begin
            if (push_ok) wptr_n = wptr + ONE;
            if (pop_ok)  rptr_n = rptr + ONE;
        end
        level_n = wptr_n - rptr_n;
    end

    // Status flags are registered from next-state pointers so they never follow the strobes combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            req       <= 1'b0;
            byte_pend <= 1'b0;
            lo_byte   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            rd_seen   <= 1'b0;
        end else begin
            wptr  <= wptr_n;
            rptr  <= rptr_n;
            level <= level_n;
            empty <= (level_n == '0);
            full  <= (level_n == FULL_L);
            req   <= (level_n >= BURST_L);
            if (cpu_flush)   byte_pend <= 1'b0;
            else if (cpu_wr) byte_pend <= !byte_pend;
            if (cpu_wr && !byte_pend) lo_byte <= cpu_wdata;
            if (ovf_ev)       overflow <= 1'b1;
            else if (err_clr) overflow <= 1'b0;
            if (unf_ev)       underflow <= 1'b1;
            else if (err_clr) underflow <= 1'b0;
            if (pop_ok) rd_seen <= 1'b1;
        end
    end

    ide_fifo_ram #(.AW(DEPTH_LOG2), .DW(16)) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wptr[DEPTH_LOG2-1:0]),
        .wdata ({cpu_wdata, lo_byte}),
        .re    (pop_ok),
        .raddr (rptr[DEPTH_LOG2-1:0]),
        .rdata (ram_q)
    );

    // RAM output is not resettable; mask it until the first real pop after reset.
    always_comb ide_rdata = rd_seen ? ram_q : 16'h0000;
endmodule

// File: tb/tb_ide_word_fifo.sv
// Self-checking bench for ide_word_fifo: vector table, corner sequences and a queue-based model.
module tb_ide_word_fifo;
    logic        clk = 1'b0;
    logic        rst, cpu_wr, cpu_flush, err_clr, ide_rd;
    logic [7:0]  cpu_wdata;
    logic [15:0] ide_rdata;
    logic [10:0] level;
    logic        empty, full, byte_pend, req, overflow, underflow;

    int checks = 0;
    int failures = 0;

    // Behavioural reference
    logic [15:0] mq[$];
    logic        m_bp, m_ovf, m_unf;
    logic [7:0]  m_lo;
    logic [15:0] m_rd;

    ide_word_fifo #(.DEPTH_LOG2(10), .BURST(8)) dut (
        .clk(clk), .rst(rst), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
        .cpu_flush(cpu_flush), .err_clr(err_clr), .ide_rd(ide_rd),
        .ide_rdata(ide_rdata), .level(level), .empty(empty), .full(full),
        .byte_pend(byte_pend), .req(req), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_bp = 1'b0; m_lo = 8'h00; m_rd = 16'h0000; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic model_step(input logic wr, input logic [7:0] wd, input logic fl,
                              input logic ec, input logic rd);
        bit is_full, is_empty, pop, push, ovf_ev, unf_ev;
        if (fl) begin
            mq.delete();
            m_bp = 1'b0;
            if (ec) begin m_ovf = 1'b0; m_unf = 1'b0; end
            return;
        end
        is_full  = (mq.size() == 1024);
        is_empty = (mq.size() == 0);
        pop    = rd && !is_empty;
        push   = wr && m_bp;
        ovf_ev = push && is_full && !pop;
        unf_ev = rd && is_empty;
        if (pop) m_rd = mq.pop_front();
        if (push && !ovf_ev) mq.push_back({wd, m_lo});
        if (wr) begin
            if (m_bp) m_bp = 1'b0;
            else begin m_lo = wd; m_bp = 1'b1; end
        end
        if (ec) begin m_ovf = 1'b0; m_unf = 1'b0; end
        if (ovf_ev) m_ovf = 1'b1;
        if (unf_ev) m_unf = 1'b1;
    endtask

    task automatic compare_all(input string name);
        logic [32:0] act, exp;
        int n;
        n = mq.size();
        act = {ide_rdata, level, empty, full, byte_pend, req, overflow, underflow};
        exp = {m_rd, 11'(n), n == 0, n == 1024, m_bp, n >= 8, m_ovf, m_unf};
        chk(name, 64'(act), 64'(exp));
    endtask

    task automatic step(input logic wr, input logic [7:0] wd, input logic fl,
                        input logic ec, input logic rd);
        cpu_wr = wr; cpu_wdata = wd; cpu_flush = fl; err_clr = ec; ide_rd = rd;
        @(posedge clk);
        model_step(wr, wd, fl, ec, rd);
        #1;
        compare_all("model");
    endtask

    task automatic push_word(input logic [15:0] w);
        step(1'b1, w[7:0], 1'b0, 1'b0, 1'b0);
        step(1'b1, w[15:8], 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  wd;
        logic        rd;
        logic [15:0] e_rdata;
        logic [10:0] e_level;
        logic        e_empty;
        logic        e_bp;
    } vec_t;

    vec_t vt[7];

    initial begin
        rst = 1'b1; cpu_wr = 0; cpu_wdata = 0; cpu_flush = 0; err_clr = 0; ide_rd = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({ide_rdata, level, empty, full, byte_pend, req, overflow, underflow}),
            64'({16'h0000, 11'd0, 1'b1, 5'b0}));
        @(negedge clk) rst = 1'b0;

        // Byte pairing and read latency
        vt[0] = '{1'b1, 8'h34, 1'b0, 16'h0000, 11'd0, 1'b1, 1'b1};
        vt[1] = '{1'b1, 8'h12, 1'b0, 16'h0000, 11'd1, 1'b0, 1'b0};
        vt[2] = '{1'b1, 8'h78, 1'b0, 16'h0000, 11'd1, 1'b0, 1'b1};
        vt[3] = '{1'b1, 8'h56, 1'b0, 16'h0000, 11'd2, 1'b0, 1'b0};
        vt[4] = '{1'b0, 8'h00, 1'b1, 16'h1234, 11'd1, 1'b0, 1'b0};
        vt[5] = '{1'b0, 8'h00, 1'b1, 16'h5678, 11'd0, 1'b1, 1'b0};
        vt[6] = '{1'b0, 8'h00, 1'b1, 16'h5678, 11'd0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            step(vt[i].wr, vt[i].wd, 1'b0, 1'b0, vt[i].rd);
            chk($sformatf("vec%0d", i), 64'({ide_rdata, level, empty, byte_pend}),
                64'({vt[i].e_rdata, vt[i].e_level, vt[i].e_empty, vt[i].e_bp}));
        end
        chk("underflow_set", 64'(underflow), 64'(1));
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("underflow_clr", 64'(underflow), 64'(0));

        // Burst request threshold
        for (int i = 0; i < 7; i++) push_word(16'(i + 16'h0100));
        chk("req_at_7", 64'({req, level}), 64'({1'b0, 11'd7}));
        push_word(16'h0107);
        chk("req_at_8", 64'({req, level}), 64'({1'b1, 11'd8}));
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("req_after_pop", 64'({req, level, ide_rdata}), 64'({1'b0, 11'd7, 16'h0100}));
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Fill, overflow, push+pop at full
        for (int i = 0; i < 1024; i++) push_word(16'($urandom));
        chk("full_set", 64'({full, level}), 64'({1'b1, 11'd1024}));
        push_word(16'hDEAD);
        chk("overflow", 64'({overflow, level, byte_pend}), 64'({1'b1, 11'd1024, 1'b0}));
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("overflow_clr", 64'(overflow), 64'(0));
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
        chk("pushpop_full", 64'({level, overflow, full}), 64'({11'd1024, 1'b0, 1'b1}));
        for (int i = 0; i < 1024; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("last_word", 64'({ide_rdata, empty}), 64'({16'hBBAA, 1'b1}));

        // Flush overrides a pending byte and a same-cycle write
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) push_word(16'($urandom));
        chk("pre_flush", 64'({level, byte_pend}), 64'({11'd5, 1'b1}));
        step(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
        chk("flush", 64'({level, empty, byte_pend, ide_rdata}), 64'({11'd0, 1'b1, 1'b0, 16'hBBAA}));

        // Async reset mid-stream
        for (int i = 0; i < 300; i++) push_word(16'($urandom));
        chk("level_300", 64'(level), 64'(300));
        cpu_wr = 0; cpu_flush = 0; err_clr = 0; ide_rd = 0;
        #2 rst = 1'b1;
        #1;
        chk("async_reset", 64'({ide_rdata, level, empty, full, byte_pend, req, overflow, underflow}),
            64'({16'h0000, 11'd0, 1'b1, 5'b0}));
        model_reset();
        @(posedge clk);
        #1 compare_all("in_reset");
        @(negedge clk) rst = 1'b0;

        // Randomized traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 199) == 0,
                 $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
